// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave modport; the byte source / memory side takes master.
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed byte stream in, 32-bit
// word writes out, CPU held in reset until an image with a good XOR checksum lands.
//
// state  | meaning
// IDLE   | waiting for start, CPU held in reset
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count
// DATA   | assembling little-endian words and writing them
// CHECK  | expecting XOR checksum byte
// DONE   | image good, CPU released
// ERROR  | length overflow or bad checksum, CPU held in reset
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t          state;
    logic [7:0]      len_lo;
    logic [16:0]     len;
    logic [7:0]      chk;
    logic [1:0]      byte_idx;
    logic [23:0]     wbuf;
    logic            accept;
    logic [ADDR_W:0] wl_next;
    logic [16:0]     len_rx;

    assign accept  = bus.in_valid & bus.in_ready;
    assign wl_next = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
    assign len_rx  = {1'b0, bus.in_data, len_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cpu_rst       <= 1'b1;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_loaded  <= '0;
            len_lo        <= '0;
            len           <= '0;
            chk           <= '0;
            byte_idx      <= '0;
            wbuf          <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN_LO;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_rst      <= 1'b1;
                        words_loaded <= '0;
                        chk          <= '0;
                        byte_idx     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.in_data;
                        chk    <= chk ^ bus.in_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        chk <= chk ^ bus.in_data;
                        len <= len_rx;
                        if (len_rx > DEPTH_L) begin
                            state        <= S_ERROR;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else if (len_rx == 17'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        chk      <= chk ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Write goes out the cycle after the 4th byte; a
                            // following CHK byte may be accepted in parallel.
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= words_loaded[ADDR_W-1:0];
                            bus.mem_wdata <= WIDTH'({bus.in_data, wbuf});
                            words_loaded  <= wl_next;
                            if (17'(wl_next) == len)
                                state <= S_CHECK;
                        end else begin
                            wbuf <= {bus.in_data, wbuf[23:8]};
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (bus.in_data == chk) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected word writes are queued as streams
// are issued and popped by an independent write monitor.
module tb_imem_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cpu_rst, busy, done, error;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W), .WIDTH(32)) bus ();

    imem_loader #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  stream[$];
    logic [39:0] exp_w;

    // write monitor: every mem_we pulse must match the head of the queue
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %h, no write expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %h, expected addr %0h data %h",
                             bus.mem_addr, bus.mem_wdata, exp_w[39:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic rdy;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: byte %h not accepted, expected acceptance", b);
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_stream(input int gap, input int stray_at);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], gap);
            if (i == stray_at) pulse_start();
        end
    endtask

    task automatic img1(input logic [7:0] chk_byte);
        stream = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                   8'h93, 8'h01, 8'hC0, 8'h00, chk_byte};
    endtask

    task automatic expect_img1();
        exp_q.push_back({8'd0, 32'h00500113});
        exp_q.push_back({8'd1, 32'h00C00193});
    endtask

    task automatic check_final(input string name, input logic d, input logic e,
                               input logic c, input int wl);
        chk({name, "_done"},     done, d);
        chk({name, "_error"},    error, e);
        chk({name, "_cpu_rst"},  cpu_rst, c);
        chk({name, "_words"},    words_loaded, wl);
        chk({name, "_busy"},     busy, 0);
        chk({name, "_in_ready"}, bus.in_ready, 0);
        chk({name, "_pending"},  exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", bus.in_ready, 0);

        // 1: two-word image, good checksum
        img1(8'h12); expect_img1();
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", bus.in_ready, 1);
        send_stream(0, -1);
        check_final("t1", 1, 0, 0, 2);

        // 2: bad checksum, then retry
        img1(8'h13); expect_img1();
        pulse_start();
        chk("t2_cpu_rst_reassert", cpu_rst, 1);
        chk("t2_done_cleared", done, 0);
        send_stream(0, -1);
        check_final("t2", 0, 1, 1, 2);
        img1(8'h12); expect_img1();
        pulse_start();
        send_stream(0, -1);
        check_final("t2_retry", 1, 0, 0, 2);

        // 3: empty image
        stream = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_stream(0, -1);
        check_final("t3", 1, 0, 0, 0);

        // 4: N = 257 exceeds depth
        stream = '{8'h01, 8'h01};
        pulse_start();
        send_stream(0, -1);
        check_final("t4", 0, 1, 1, 0);
        repeat (3) @(posedge clk); #1;
        chk("t4_in_ready_hold", bus.in_ready, 0);

        // 5: gapped stream with stray start inside DATA
        img1(8'h12); expect_img1();
        pulse_start();
        send_stream(3, 5);
        check_final("t5", 1, 0, 0, 2);

        // 6: reset after the 6th byte, then full reload
        img1(8'h12);
        exp_q.push_back({8'd0, 32'h00500113});
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_cpu_rst", cpu_rst, 1);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_error", error, 0);
        chk("t6_words", words_loaded, 0);
        chk("t6_in_ready", bus.in_ready, 0);
        chk("t6_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        expect_img1();
        pulse_start();
        send_stream(0, -1);
        check_final("t6_reload", 1, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory.
- Accepts a byte stream with a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one-cycle word writes at sequential addresses starting from 0.
- Holds the CPU in reset until a complete image with a correct checksum has been written.
- Sits between the host/UART byte source and the instruction memory's write port.

Parameters:
- DEPTH, 256, number of instruction words in memory; ADDR_W = $clog2(DEPTH).
- WIDTH, 32, instruction word width in bits; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  WIDTH  word being written.
- cpu_rst  output  1  active-high reset to the CPU core.
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum.
- error  output  1  last load failed (length overflow or bad checksum).
- words_loaded  output  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset (asynchronous, at any time including mid-load) forces:
  - state = IDLE;
  - cpu_rst = 1;
  - in_ready, mem_we, busy, done, error = 0;
  - mem_addr, mem_wdata, words_loaded, checksum, byte index = 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word little-endian, byte 0 = bits 7:0), then CHK.
  - CHK must equal the XOR of all preceding bytes, including the length bytes.
- States and transitions:
  - IDLE: in_ready = 0. On start: clear counters, checksum, done and error; go to LEN_LO.
  - LEN_LO: in_ready = 1. On accept, store the low byte and go to LEN_HI.
  - LEN_HI: in_ready = 1. On accept:
    - if N > DEPTH, go to ERROR;
    - else if N == 0, go to CHECK;
    - else go to DATA.
  - DATA: in_ready = 1. Shift accepted bytes into the word register.
    - On the 4th byte: next cycle, mem_we = 1 for exactly one cycle, with mem_addr = current word index and mem_wdata = assembled word.
    - words_loaded increments in that same cycle.
    - After word N is accepted, go to CHECK.
  - CHECK: in_ready = 1. On accept:
    - go to DONE if the byte equals the running XOR;
    - else go to ERROR.
  - DONE: done = 1, cpu_rst = 0, in_ready = 0. start returns to LEN_LO and reasserts cpu_rst the next cycle.
  - ERROR: error = 1, cpu_rst = 1, in_ready = 0. start retries the load via LEN_LO.
- busy = 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
- cpu_rst is 0 only in DONE.
- start received in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- When in_valid = 0, the loader stalls with no state change; arbitrary gaps between bytes are legal.
- Bytes presented while in_ready = 0 are not consumed.
- Word writes are never issued for a partial word.
- Words already written before an error remain in memory; there is no rollback.
- A word write pulse and the CHK byte may overlap. The write always completes before the DONE/ERROR decision becomes visible.
- The address counter never wraps, because N ≤ DEPTH is enforced.

Test Plan:
1. Bytes 02 00 13 01 50 00 93 01 C0 00 12, no gaps.
   - Expect mem_we pulses {addr 0, 0x00500113} and {addr 1, 0x00C00193}.
   - Then done = 1, error = 0, cpu_rst = 0, words_loaded = 2.
2. Same stream with CHK = 0x13.
   - Expect both writes to occur, then error = 1, done = 0, cpu_rst = 1.
   - A subsequent start with the correct stream ends in done = 1.
3. Bytes 00 00 00 (N = 0).
   - Expect no mem_we pulse, done = 1, cpu_rst = 0, words_loaded = 0.
4. With DEPTH = 256, bytes 01 01 (N = 257).
   - Expect error = 1 immediately after the second byte, in_ready = 0, no writes, cpu_rst = 1.
5. Test 1's stream with in_valid low for 3 cycles between every byte, plus a start pulse injected mid-DATA.
   - Expect identical writes and final flags.
   - The stray start has no effect.
6. Assert rst after the 6th byte of test 1's stream.
   - Expect immediate IDLE, cpu_rst = 1, all flags 0, words_loaded = 0.
   - A fresh start with the full stream loads correctly.
